debug_unit: RTL and testbench

DEBUG_UNIT -- requirements
Module: debug_unit

---
 rtl/debug_unit_pkg.sv | 26 ++
 rtl/debug_unit_rx_edge.sv | 20 ++
 rtl/debug_unit.sv | 153 +++++++++++++++
 tb/tb_debug_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_unit_pkg.sv
// Shared encodings and constants for the MIPS debug/loader controller.
package debug_unit_pkg;

  localparam int ADDR_W = 11;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD      = 3'd1;
  localparam logic [2:0] ST_WAIT_MODE = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_STEP      = 3'd4;
  localparam logic [2:0] ST_SEND      = 3'd5;

  localparam logic [2:0] SUB_BYTE0 = 3'd0;
  localparam logic [2:0] SUB_BYTE1 = 3'd1;
  localparam logic [2:0] SUB_BYTE2 = 3'd2;
  localparam logic [2:0] SUB_BYTE3 = 3'd3;
  localparam logic [2:0] SUB_WRITE = 3'd4;

  localparam logic [7:0] CMD_LOAD = 8'h01;
  localparam logic [7:0] CMD_RUN  = 8'h02;
  localparam logic [7:0] CMD_STEP = 8'h03;
  localparam logic [7:0] CMD_CLK  = 8'h04;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/debug_unit_rx_edge.sv
// One-cycle pulse on the rising edge of the UART receive-done level.
module rx_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic rx_done_tick,
  output logic rx_pulse
);

  logic rx_prev_q, rx_prev_d;

  always_comb rx_prev_d = rx_done_tick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rx_prev_q <= 1'b0;
    else        rx_prev_q <= rx_prev_d;
  end

  assign rx_pulse = rx_done_tick & ~rx_prev_q;

endmodule

// File: rtl/debug_unit.sv
// UART-driven loader and run/step controller for the MIPS core.
//   state     | meaning
//   IDLE      | wait for load command byte
//   LOAD      | assemble 4 bytes LSB first, write word, repeat until halt word
//   WAIT_MODE | wait for run or step command
//   RUN       | MIPS clock enabled until halt
//   STEP      | one MIPS clock per step byte
//   SEND      | transmit test_reg byte, wait for transmitter done
module debug_unit
  import debug_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              halt,
  input  logic [7:0]        test_reg,
  input  logic              rx_done_tick,
  input  logic [7:0]        rx_data_in,
  input  logic              tx_done_tick,
  output logic [ADDR_W-1:0] addr_mem_inst,
  output logic [31:0]       ins_to_mem,
  output logic              wr_ram_inst,
  output logic [31:0]       test,
  output logic [2:0]        substate_flag,
  output logic [2:0]        substatenext_flag,
  output logic              ctrl_clk_mips,
  output logic              debug,
  output logic              tx_start,
  output logic [7:0]        data_out
);

  logic              rx_pulse;
  logic [2:0]        state_q, state_d;
  logic [2:0]        sub_q, sub_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              debug_q, debug_d;
  logic              halt_seen_q, halt_seen_d;
  logic              tx_start_q, tx_start_d;

  rx_edge_detect u_rx_edge (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_pulse     (rx_pulse)
  );

  always_comb begin
    state_d       = state_q;
    sub_d         = sub_q;
    addr_d        = addr_q;
    word_d        = word_q;
    data_out_d    = data_out_q;
    debug_d       = debug_q;
    halt_seen_d   = halt_seen_q;
    tx_start_d    = 1'b0;
    wr_ram_inst   = 1'b0;
    ctrl_clk_mips = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_pulse && rx_data_in == CMD_LOAD) begin
          state_d = ST_LOAD;
          sub_d   = SUB_BYTE0;
        end
      end
      ST_LOAD: begin
        if (sub_q == SUB_WRITE) begin
          wr_ram_inst = 1'b1;
          addr_d      = addr_q + ADDR_W'(1);
          sub_d       = SUB_BYTE0;
          if (word_q == HALT_WORD) state_d = ST_WAIT_MODE;
        end else if (rx_pulse) begin
          word_d = {rx_data_in, word_q[31:8]};
          sub_d  = sub_q + 3'd1;
        end
      end
      ST_WAIT_MODE: begin
        if (rx_pulse && rx_data_in == CMD_RUN) begin
          state_d = ST_RUN;
        end else if (rx_pulse && rx_data_in == CMD_STEP) begin
          state_d = ST_STEP;
          debug_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (halt) begin
          state_d     = ST_SEND;
          halt_seen_d = 1'b1;
        end else begin
          ctrl_clk_mips = 1'b1;
        end
      end
      ST_STEP: begin
        // halt wins over a step byte arriving in the same cycle
        if (halt) begin
          state_d     = ST_SEND;
          halt_seen_d = 1'b1;
        end else if (rx_pulse && rx_data_in == CMD_CLK) begin
          ctrl_clk_mips = 1'b1;
          state_d       = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_done_tick && !tx_start_q) begin
          halt_seen_d = 1'b0;
          if (debug_q && !halt_seen_q) begin
            state_d = ST_STEP;
          end else begin
            state_d = ST_IDLE;
            debug_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_SEND && state_q != ST_SEND) begin
      tx_start_d = 1'b1;
      data_out_d = test_reg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      sub_q       <= SUB_BYTE0;
      addr_q      <= '0;
      word_q      <= '0;
      data_out_q  <= '0;
      debug_q     <= 1'b0;
      halt_seen_q <= 1'b0;
      tx_start_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sub_q       <= sub_d;
      addr_q      <= addr_d;
      word_q      <= word_d;
      data_out_q  <= data_out_d;
      debug_q     <= debug_d;
      halt_seen_q <= halt_seen_d;
      tx_start_q  <= tx_start_d;
    end
  end

  assign addr_mem_inst     = addr_q;
  assign ins_to_mem        = word_q;
  assign test              = word_q;
  assign substate_flag     = sub_q;
  assign substatenext_flag = sub_d;
  assign debug             = debug_q;
  assign tx_start          = tx_start_q;
  assign data_out          = data_out_q;

endmodule

// File: tb/tb_debug_unit.sv
// Directed bench for debug_unit: byte-table load checks plus run/step/reset sequences.
module tb_debug_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        halt = 1'b0;
  logic [7:0]  test_reg = 8'h00;
  logic        rx_done_tick = 1'b0;
  logic [7:0]  rx_data_in = 8'h00;
  logic        tx_done_tick = 1'b0;
  logic [10:0] addr_mem_inst;
  logic [31:0] ins_to_mem;
  logic        wr_ram_inst;
  logic [31:0] test;
  logic [2:0]  substate_flag;
  logic [2:0]  substatenext_flag;
  logic        ctrl_clk_mips;
  logic        debug;
  logic        tx_start;
  logic [7:0]  data_out;

  int total = 0;
  int bad = 0;

  int          wr_cnt = 0;
  int          ctrl_cnt = 0;
  int          tx_cnt = 0;
  logic [7:0]  tx_data = 8'h00;
  logic [10:0] last_a = '0;
  logic [31:0] last_d = '0;
  logic [10:0] log_a [4];
  logic [31:0] log_d [4];

  debug_unit dut (
    .clk               (clk),
    .reset             (reset),
    .halt              (halt),
    .test_reg          (test_reg),
    .rx_done_tick      (rx_done_tick),
    .rx_data_in        (rx_data_in),
    .tx_done_tick      (tx_done_tick),
    .addr_mem_inst     (addr_mem_inst),
    .ins_to_mem        (ins_to_mem),
    .wr_ram_inst       (wr_ram_inst),
    .test              (test),
    .substate_flag     (substate_flag),
    .substatenext_flag (substatenext_flag),
    .ctrl_clk_mips     (ctrl_clk_mips),
    .debug             (debug),
    .tx_start          (tx_start),
    .data_out          (data_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_ram_inst) begin
      if (wr_cnt < 4) begin
        log_a[wr_cnt] = addr_mem_inst;
        log_d[wr_cnt] = ins_to_mem;
      end
      last_a = addr_mem_inst;
      last_d = ins_to_mem;
      wr_cnt++;
    end
    if (ctrl_clk_mips) ctrl_cnt++;
    if (tx_start) begin
      tx_cnt++;
      tx_data = data_out;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap,
                           output logic [2:0] sub_seen);
    @(posedge clk); #1;
    rx_data_in   = b;
    rx_done_tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sub_seen = substate_flag;
    if (hold > 1) begin
      repeat (hold - 1) @(posedge clk);
      #1;
    end
    rx_done_tick = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic do_tx(input int t0);
    int k;
    k = 0;
    while (tx_cnt == t0 && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk("tx_start_pulses", 32'(tx_cnt - t0), 32'd1);
    @(posedge clk); #1 tx_done_tick = 1'b1;
    @(posedge clk); #1 tx_done_tick = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  typedef struct {
    logic [7:0] b;
    logic [2:0] sub;
    int         wr;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [2:0] s;
    int c0, t0, w0, n;

    vecs[0]  = '{8'h01, 3'd0, 0};
    vecs[1]  = '{8'hDD, 3'd1, 0};
    vecs[2]  = '{8'hCC, 3'd2, 0};
    vecs[3]  = '{8'hBB, 3'd3, 0};
    vecs[4]  = '{8'hAA, 3'd4, 1};
    vecs[5]  = '{8'h44, 3'd1, 1};
    vecs[6]  = '{8'h33, 3'd2, 1};
    vecs[7]  = '{8'h22, 3'd3, 1};
    vecs[8]  = '{8'h11, 3'd4, 2};
    vecs[9]  = '{8'hFF, 3'd1, 2};
    vecs[10] = '{8'hFF, 3'd2, 2};
    vecs[11] = '{8'hFF, 3'd3, 2};
    vecs[12] = '{8'hFF, 3'd4, 3};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {wr_ram_inst, ctrl_clk_mips, debug, tx_start, data_out}, 32'd0);
    chk("rst_substate", 32'(substate_flag), 32'd0);
    chk("rst_addr", 32'(addr_mem_inst), 32'd0);
    chk("rst_test", test, 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    test_reg = 8'h5A;

    // load three words from the table
    for (int i = 0; i < 13; i++) begin
      send_byte(vecs[i].b, 2, 2, s);
      chk($sformatf("vec%0d_sub", i), 32'(s), 32'(vecs[i].sub));
      chk($sformatf("vec%0d_wr", i), 32'(wr_cnt), 32'(vecs[i].wr));
      if (vecs[i].sub == 3'd4) chk($sformatf("vec%0d_sub_back", i), 32'(substate_flag), 32'd0);
    end
    chk("w0_addr", 32'(log_a[0]), 32'd0);
    chk("w0_data", log_d[0], 32'hAABBCCDD);
    chk("w1_addr", 32'(log_a[1]), 32'd1);
    chk("w1_data", log_d[1], 32'h11223344);
    chk("w2_addr", 32'(log_a[2]), 32'd2);
    chk("w2_data", log_d[2], 32'hFFFFFFFF);
    chk("addr_after_halt_word", 32'(addr_mem_inst), 32'd3);
    chk("test_is_word", test, 32'hFFFFFFFF);

    // run mode: ten enabled cycles then halt
    c0 = ctrl_cnt; t0 = tx_cnt;
    @(posedge clk); #1 rx_data_in = 8'h02; rx_done_tick = 1'b1;
    @(posedge clk); #1 rx_done_tick = 1'b0;
    n = 0;
    for (int k = 0; k < 50 && n < 10; k++) begin
      @(negedge clk);
      if (ctrl_clk_mips) n++;
    end
    chk("run_reached_10", 32'(n), 32'd10);
    @(posedge clk); #1 halt = 1'b1;
    @(negedge clk);
    chk("run_ctrl_low_on_halt", 32'(ctrl_clk_mips), 32'd0);
    @(posedge clk); #1 halt = 1'b0;
    do_tx(t0);
    chk("run_ctrl_cycles", 32'(ctrl_cnt - c0), 32'd10);
    chk("run_tx_data", 32'(tx_data), 32'h5A);
    chk("run_debug", 32'(debug), 32'd0);
    c0 = ctrl_cnt;
    send_byte(8'h02, 2, 4, s);
    chk("idle_ignores_run", 32'(ctrl_cnt - c0), 32'd0);

    // reload a halt word at address 3, then step mode
    send_byte(8'h01, 2, 2, s);
    for (int i = 0; i < 4; i++) send_byte(8'hFF, 2, 2, s);
    chk("reload_addr", 32'(last_a), 32'd3);
    send_byte(8'h03, 2, 2, s);
    chk("step_debug_on", 32'(debug), 32'd1);
    for (int i = 0; i < 2; i++) begin
      c0 = ctrl_cnt; t0 = tx_cnt;
      test_reg = 8'h30 + 8'(i);
      send_byte(8'h04, 2, 2, s);
      do_tx(t0);
      chk($sformatf("step%0d_ctrl", i), 32'(ctrl_cnt - c0), 32'd1);
      chk($sformatf("step%0d_tx_data", i), 32'(tx_data), 32'(8'h30 + 8'(i)));
      chk($sformatf("step%0d_debug", i), 32'(debug), 32'd1);
    end
    c0 = ctrl_cnt; t0 = tx_cnt;
    @(posedge clk); #1 halt = 1'b1;
    @(posedge clk); #1 halt = 1'b0;
    do_tx(t0);
    chk("step_halt_ctrl", 32'(ctrl_cnt - c0), 32'd0);
    chk("step_halt_debug", 32'(debug), 32'd0);

    // reset in BYTE2
    send_byte(8'h01, 2, 2, s);
    send_byte(8'hDD, 2, 2, s);
    send_byte(8'hCC, 2, 2, s);
    chk("pre_rst_sub", 32'(substate_flag), 32'd2);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_sub", {26'd0, substate_flag, substatenext_flag}, 32'd0);
    chk("mid_rst_addr", 32'(addr_mem_inst), 32'd0);
    chk("mid_rst_word", test, 32'd0);
    chk("mid_rst_outs", {wr_ram_inst, ctrl_clk_mips, debug, tx_start, data_out}, 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    w0 = wr_cnt;
    send_byte(8'h01, 2, 2, s);
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 2, 2, s);
    chk("post_rst_wr", 32'(wr_cnt - w0), 32'd1);
    chk("post_rst_addr", 32'(last_a), 32'd0);
    chk("post_rst_data", last_d, 32'h04030201);

    // fill the remaining addresses to exercise the wrap
    for (int w = 1; w < 2048; w++) begin
      send_byte(8'(w), 1, 0, s);
      send_byte(8'(w >> 8), 1, 0, s);
      send_byte(8'h00, 1, 0, s);
      send_byte(8'h00, 1, 0, s);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("wrap_wr_count", 32'(wr_cnt - w0), 32'd2048);
    chk("wrap_last_addr", 32'(last_a), 32'd2047);
    chk("wrap_last_data", last_d, 32'd2047);
    chk("wrap_addr", 32'(addr_mem_inst), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
